// File: rtl/shift_unit_core.sv
// Registered shifter/rotator: arithmetic, rotate, logical and pass-through with a zero flag.
// Define SHIFT_UNIT_CARRY_EN to add the registered carry-out port co.
module shift_unit_core #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] b,
    input  logic [4:0]       shamt,
    input  logic             A,
    input  logic             R,
    input  logic             L,
    input  logic             drxn,
    output logic [WIDTH-1:0] B,
`ifdef SHIFT_UNIT_CARRY_EN
    output logic             co,
`endif
    output logic             zf
);

    logic [WIDTH-1:0] next_b;
    logic             next_zf;

    always_comb begin
        next_b = b;
        if (A) begin
            if (drxn)
                next_b = $signed(b) >>> shamt;
            else
                next_b = b << shamt;
        end else if (R) begin
            // A shift by the full width yields zero, so shamt = 0 degenerates to b.
            if (drxn)
                next_b = (b >> shamt) | (b << (WIDTH - 32'(shamt)));
            else
                next_b = (b << shamt) | (b >> (WIDTH - 32'(shamt)));
        end else if (L) begin
            if (drxn)
                next_b = b >> shamt;
            else
                next_b = b << shamt;
        end
        next_zf = (next_b == '0);
    end

`ifdef SHIFT_UNIT_CARRY_EN
    logic [WIDTH:0] right_ext;
    logic [WIDTH:0] left_ext;
    logic           next_co;

    // Padding by one bit leaves the last bit shifted out at the pad position; zero when shamt = 0.
    always_comb begin
        right_ext = {b, 1'b0} >> shamt;
        left_ext  = {1'b0, b} << shamt;
        next_co   = 1'b0;
        if (A || R || L)
            next_co = drxn ? right_ext[0] : left_ext[WIDTH];
    end

    always_ff @(posedge clk) begin
        if (rst)
            co <= 1'b0;
        else
            co <= next_co;
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            B  <= '0;
            zf <= 1'b1;
        end else begin
            B  <= next_b;
            zf <= next_zf;
        end
    end

endmodule

// File: tb/tb_shift_unit_core.sv
// Self-checking bench for shift_unit_core: directed vector table, reset sequence, randomized model compare.
// co is checked only when SHIFT_UNIT_CARRY_EN is defined.
module tb_shift_unit_core;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] b;
    logic [4:0]  shamt;
    logic        A, R, L, drxn;
    logic [31:0] B;
    logic        zf;
`ifdef SHIFT_UNIT_CARRY_EN
    logic        co;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    shift_unit_core #(.WIDTH(32)) dut (
        .clk   (clk),
        .rst   (rst),
        .b     (b),
        .shamt (shamt),
        .A     (A),
        .R     (R),
        .L     (L),
        .drxn  (drxn),
        .B     (B),
`ifdef SHIFT_UNIT_CARRY_EN
        .co    (co),
`endif
        .zf    (zf)
    );

    typedef struct {
        logic [31:0] b;
        logic [4:0]  s;
        logic        a, r, l, d;
        logic [31:0] exp_b;
        logic        exp_z;
        logic        exp_c;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_outputs(input string name, input logic [31:0] eb, input logic ez, input logic ec);
        check({name, ".B"}, B, eb);
        check({name, ".zf"}, 32'(zf), 32'(ez));
`ifdef SHIFT_UNIT_CARRY_EN
        check({name, ".co"}, 32'(co), 32'(ec));
`endif
    endtask

    // Bit-level statement of the rules: each result bit names its source bit or fill.
    function automatic void model(input logic [31:0] vb, input logic [4:0] vs,
                                  input logic va, input logic vr, input logic vl, input logic vd,
                                  output logic [31:0] res, output logic c);
        int n = int'(vs);
        res = vb;
        c   = 1'b0;
        if (!(va || vr || vl)) return;
        for (int i = 0; i < 32; i++) begin
            int src = vd ? i + n : i - n;
            if (va) begin
                if (vd) res[i] = (src < 32) ? vb[src] : vb[31];
                else    res[i] = (src >= 0) ? vb[src] : 1'b0;
            end else if (vr) begin
                res[i] = vb[(src + 32) % 32];
            end else begin
                res[i] = (src >= 0 && src < 32) ? vb[src] : 1'b0;
            end
        end
        if (n > 0) c = vd ? vb[n-1] : vb[32-n];
    endfunction

    task automatic apply(input logic [31:0] vb, input logic [4:0] vs,
                         input logic va, input logic vr, input logic vl, input logic vd);
        b = vb; shamt = vs; A = va; R = vr; L = vl; drxn = vd;
        @(posedge clk);
        #1;
    endtask

    vec_t vecs[14];

    initial begin
        logic [31:0] mb;
        logic        mc;

        vecs[0]  = '{32'hFFFFA780, 5'd1,  1, 0, 0, 1, 32'hFFFFD3C0, 0, 0};
        vecs[1]  = '{32'hFFFFA780, 5'd1,  1, 0, 0, 0, 32'hFFFF4F00, 0, 1};
        vecs[2]  = '{32'hFFFFA780, 5'd1,  0, 0, 1, 1, 32'h7FFFD3C0, 0, 0};
        vecs[3]  = '{32'hFFFFA780, 5'd1,  0, 0, 1, 0, 32'hFFFF4F00, 0, 1};
        vecs[4]  = '{32'hFFFFA780, 5'd1,  0, 1, 0, 1, 32'h7FFFD3C0, 0, 0};
        vecs[5]  = '{32'hFFFFA780, 5'd1,  0, 1, 0, 0, 32'hFFFF4F01, 0, 1};
        vecs[6]  = '{32'hFFFFA780, 5'd1,  0, 0, 0, 1, 32'hFFFFA780, 0, 0};
        vecs[7]  = '{32'hFFFFA780, 5'd1,  1, 1, 1, 1, 32'hFFFFD3C0, 0, 0};
        vecs[8]  = '{32'h80000000, 5'd31, 0, 0, 1, 1, 32'h00000001, 0, 0};
        vecs[9]  = '{32'h80000000, 5'd1,  0, 0, 1, 0, 32'h00000000, 1, 1};
        vecs[10] = '{32'h12345678, 5'd0,  0, 1, 0, 0, 32'h12345678, 0, 0};
        vecs[11] = '{32'h80000000, 5'd31, 1, 0, 0, 1, 32'hFFFFFFFF, 0, 0};
        vecs[12] = '{32'h00000003, 5'd31, 0, 1, 0, 0, 32'h80000001, 0, 1};
        vecs[13] = '{32'h00000000, 5'd0,  0, 0, 0, 0, 32'h00000000, 1, 0};

        rst = 1'b1; b = 32'hDEADBEEF; shamt = 5'd3; A = 1'b0; R = 1'b1; L = 1'b0; drxn = 1'b1;
        @(posedge clk);
        #1;
        check_outputs("reset_init", 32'h0, 1'b1, 1'b0);
        rst = 1'b0;

        for (int i = 0; i < 14; i++) begin
            apply(vecs[i].b, vecs[i].s, vecs[i].a, vecs[i].r, vecs[i].l, vecs[i].d);
            check_outputs($sformatf("vec%0d", i), vecs[i].exp_b, vecs[i].exp_z, vecs[i].exp_c);
        end

        // Mid-stream reset overrides a carry-producing rotate, then release resumes with no gap.
        apply(32'hFFFFA780, 5'd1, 1'b0, 1'b1, 1'b0, 1'b0);
        check_outputs("pre_reset", 32'hFFFF4F01, 1'b0, 1'b1);
        rst = 1'b1;
        apply(32'hFFFFA780, 5'd1, 1'b0, 1'b1, 1'b0, 1'b0);
        check_outputs("mid_reset", 32'h0, 1'b1, 1'b0);
        rst = 1'b0;
        apply(32'hFFFFA780, 5'd1, 1'b1, 1'b0, 1'b0, 1'b0);
        check_outputs("post_reset", 32'hFFFF4F00, 1'b0, 1'b1);

        for (int i = 0; i < 400; i++) begin
            logic [31:0] rb;
            logic [4:0]  rs;
            logic [3:0]  sel;
            rb  = $urandom;
            if ($urandom_range(0, 7) == 0) rb = 32'h0;
            rs  = 5'($urandom_range(0, 31));
            sel = 4'($urandom);
            model(rb, rs, sel[0], sel[1], sel[2], sel[3], mb, mc);
            apply(rb, rs, sel[0], sel[1], sel[2], sel[3]);
            check_outputs($sformatf("rand%0d", i), mb, (mb == 32'h0), mc);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/shift_unit_core.md
SHIFT_UNIT_CORE -- requirements
Module: shift_unit

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the data width of b and B.
REQ-002 Port clk SHALL be an input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 Port rst SHALL be an input, 1 bit: synchronous, active-high reset.
REQ-004 Port b SHALL be an input, WIDTH bits: the operand to shift.
REQ-005 Port shamt SHALL be an input, 5 bits: shift or rotate amount, 0..31.
REQ-006 Port A SHALL be an input, 1 bit: selects arithmetic shift.
REQ-007 Port R SHALL be an input, 1 bit: selects rotate.
REQ-008 Port L SHALL be an input, 1 bit: selects logical shift.
REQ-009 Port drxn SHALL be an input, 1 bit: direction, 1 = right, 0 = left.
REQ-010 Port B SHALL be an output, WIDTH bits: the registered result.
REQ-011 Port zf SHALL be an output, 1 bit: registered zero flag, 1 when the result is zero.
REQ-012 Port co SHALL be an output, 1 bit: registered carry-out; present only when SHIFT_UNIT_CARRY_EN is defined.

Function
REQ-013 Latency SHALL be one cycle: B, zf and co are captured at each rising clk edge from the inputs sampled at that edge; no handshake.
REQ-014 Mode priority SHALL be A > R > L when more than one select is high.
REQ-015 When none of A, R, L is high, B SHALL be loaded with b unchanged.
REQ-016 Arithmetic right SHALL fill vacated MSBs with b[WIDTH-1].
REQ-017 Arithmetic left SHALL be identical to logical left, zero-filling LSBs.
REQ-018 Logical right and logical left SHALL zero-fill vacated bits.
REQ-019 Rotate right and rotate left SHALL move bits out of one end into the other, with no loss.
REQ-020 When shamt = 0, the result SHALL be b in every mode.
REQ-021 zf SHALL equal 1 exactly when the next value of B is all zeros.
REQ-022 co SHALL be the last bit shifted or rotated out: b[shamt-1] for right, b[WIDTH-shamt] for left; 0 when shamt = 0 or when passing b through.

Reset
REQ-023 When rst is high at a rising edge, the block SHALL set B = 0, zf = 1 and co = 0, overriding all other inputs.
REQ-024 Releasing rst SHALL let the block resume normal operation on the next edge with no extra latency.

Configuration
REQ-025 With SHIFT_UNIT_CARRY_EN defined, the co port and its register SHALL exist as specified.
REQ-026 Without SHIFT_UNIT_CARRY_EN, the co port and its logic SHALL be absent, and B and zf SHALL be unaffected.

Verification
REQ-027 Arithmetic shift: b=FFFFA780, shamt=1, A=1, drxn=1 -> B=FFFFD3C0, co=0; with drxn=0 -> B=FFFF4F00, co=1.
REQ-028 Logical shift: b=FFFFA780, shamt=1, L=1, drxn=1 -> B=7FFFD3C0; with drxn=0 -> B=FFFF4F00.
REQ-029 Rotate: b=FFFFA780, shamt=1, R=1, drxn=1 -> B=7FFFD3C0; with drxn=0 -> B=FFFF4F01, co=1.
REQ-030 Pass-through and priority: all selects low -> B=b, co=0; A=R=L=1 with drxn=1 -> arithmetic-right result.
REQ-031 Boundaries: b=80000000, L=1, drxn=1, shamt=31 -> B=00000001; drxn=0, shamt=1 -> B=0, zf=1, co=1.
REQ-032 Reset: rst=1 mid-stream -> next edge gives B=0, zf=1, co=0; rst=0 -> the following edge gives the correct result.
